iterative_normalizer: RTL and testbench

- Multi-cycle inverse of the datapath shift unit: takes a BITS-wide operand and left-shifts it one bit per clock until it is normalized.
- Returns the normalized value and the shift count that produced it, so the existing shifter can later restore the original with a right shift by that count.
- Supports unsigned normalization (leading-one to MSB) and signed/arithmetic normalization (sign bit differs from next bit).
- Sits beside the shifter in the ALU datapath; valid/ready handshakes on both sides.

---
 rtl/iterative_normalizer_if.sv | 26 ++
 rtl/iterative_normalizer.sv | 92 +++++++++
 tb/tb_iterative_normalizer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/iterative_normalizer_if.sv
// Handshake bundle between the iterative normalizer and its producer/consumer.
// The master side drives operands and accepts results; the slave side is the normalizer.
interface iterative_normalizer_if #(
  parameter int BITS = 16,
  parameter int CW   = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] a;
  logic            mode;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] result;
  logic [CW-1:0]   count;
  logic            zero;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, result, count, zero
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, result, count, zero
  );
endinterface

// File: rtl/iterative_normalizer.sv
// Multi-cycle normalizer: left-shifts an operand one bit per clock until its leading
// one (unsigned) or its first non-sign bit (signed) reaches the top, reporting the shift count.
module iterative_normalizer #(
  parameter int BITS = 16,
  parameter int CW   = 5
) (
  input logic                 clk,
  input logic                 rst,
  iterative_normalizer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] result_q, result_d;
  logic [CW-1:0]   count_q, count_d;
  logic            zero_q, zero_d;
  logic            mode_q, mode_d;
  logic            normalized;

  // Signed operands are normalized once the sign bit and the bit below it disagree.
  assign normalized = mode_q ? (result_q[BITS-1] != result_q[BITS-2])
                             : result_q[BITS-1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    zero_d   = zero_q;
    mode_d   = mode_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.mode;
          count_d = '0;
          zero_d  = 1'b0;
          if (!bus.mode && bus.a == '0) begin
            result_d = '0;
            count_d  = CW'(BITS);
            zero_d   = 1'b1;
            state_d  = DONE;
          end else if (bus.mode && (bus.a == '0 || bus.a == '1)) begin
            // All-sign operands would never reach the normalized condition; finish in one step.
            result_d = bus.a << (BITS-1);
            count_d  = CW'(BITS-1);
            state_d  = DONE;
          end else begin
            result_d = bus.a;
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (normalized) begin
          state_d = DONE;
        end else begin
          result_d = result_q << 1;
          count_d  = count_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      count_q  <= '0;
      zero_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      zero_q   <= zero_d;
      mode_q   <= mode_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.result    = result_q;
  assign bus.count     = count_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_iterative_normalizer.sv
// Self-checking bench for iterative_normalizer: directed cases followed by a random
// regression compared against a leading-zero / leading-sign counting model.
module tb_iterative_normalizer;
  localparam int BITS = 16;
  localparam int CW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  iterative_normalizer_if #(.BITS(BITS), .CW(CW)) bus ();

  iterative_normalizer #(.BITS(BITS), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: count leading zeros (unsigned) or redundant sign bits (signed).
  task automatic model(input logic [BITS-1:0] a, input logic m,
                       output logic [BITS-1:0] r, output int c, output logic z,
                       output int lat);
    int n;
    n = 0;
    z = 1'b0;
    if (!m) begin
      if (a == 0) begin
        r = '0; c = BITS; z = 1'b1; lat = 1;
        return;
      end
      while (!a[BITS-1-n]) n++;
      lat = n + 2;
    end else begin
      while (n < BITS-1 && a[BITS-2-n] == a[BITS-1]) n++;
      lat = (n == BITS-1) ? 1 : n + 2;
    end
    r = a << n;
    c = n;
  endtask

  // Runs one operation, holding out_ready low for bp cycles once the result is up.
  task automatic run_op(input string tag, input logic [BITS-1:0] a, input logic m, input int bp);
    logic [BITS-1:0] er;
    logic            ez;
    int              ec, elat, edges;
    model(a, m, er, ec, ez, elat);
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = a;
    bus.mode      = m;
    bus.out_ready = 1'b0;
    @(posedge clk);
    edges = 1;
    #1;
    bus.in_valid = 1'b0;
    bus.a        = ~a;
    while (!bus.out_valid && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    check({tag, ".latency"}, 32'(edges), 32'(elat));
    check({tag, ".result"}, 32'(bus.result), 32'(er));
    check({tag, ".count"}, 32'(bus.count), 32'(ec));
    check({tag, ".zero"}, 32'(bus.zero), 32'(ez));
    if (!ez) begin
      if (m) check({tag, ".inv_s"}, 32'($signed(bus.result) >>> bus.count), 32'($signed(a)));
      else   check({tag, ".inv_u"}, 32'(bus.result >> bus.count), 32'(a));
    end
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      bus.in_valid = i[0];
      bus.a        = 16'h0001;
      bus.mode     = 1'b0;
      @(posedge clk);
      #1;
      check({tag, ".bp_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, ".bp_ready"}, 32'(bus.in_ready), 32'd0);
      check({tag, ".bp_result"}, 32'(bus.result), 32'(er));
      check({tag, ".bp_count"}, 32'(bus.count), 32'(ec));
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, ".post_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, ".post_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    logic [BITS-1:0] ra;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.mode      = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.result", 32'(bus.result), 32'd0);
    check("rst.count", 32'(bus.count), 32'd0);
    check("rst.zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a long shift sequence.
    bus.in_valid = 1'b1;
    bus.a        = 16'h0001;
    bus.mode     = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid.busy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid.in_ready", 32'(bus.in_ready), 32'd1);
    check("mid.out_valid", 32'(bus.out_valid), 32'd0);
    check("mid.result", 32'(bus.result), 32'd0);
    check("mid.count", 32'(bus.count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("u0001", 16'h0001, 1'b0, 0);
    run_op("u8000", 16'h8000, 1'b0, 0);
    run_op("u0000", 16'h0000, 1'b0, 0);
    run_op("sFFF0", 16'hFFF0, 1'b1, 0);
    run_op("s0003", 16'h0003, 1'b1, 0);
    run_op("sFFFF", 16'hFFFF, 1'b1, 0);
    run_op("s0000", 16'h0000, 1'b1, 0);
    run_op("s4000", 16'h4000, 1'b1, 0);
    run_op("bp00F0", 16'h00F0, 1'b0, 5);

    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      // Bias some operands toward small magnitudes to exercise long shift runs.
      if (($urandom & 3) == 0) ra = ra >> $urandom_range(0, BITS);
      run_op("rand", ra, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
